// File: rtl/viterbi_param_decoder.sv
// viterbi_param_decoder: hard-decision Viterbi decoder for rate 1/N codes.
// Register-exchange survivors, min-normalised metrics and a sync monitor.
module viterbi_param_decoder #(
    parameter int N = 2,
    parameter int K = 3,
    parameter logic [N*K-1:0] G = 6'b111101,
    parameter int W = 8,
    parameter int D = 15,
    parameter int SYNC_WIN = 64,
    parameter int SYNC_THR = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] Rx,
    input  logic         seq_ready,
    output logic         Dx,
    output logic         oe,
    output logic         sync_error
);
    localparam int S  = 1 << (K - 1);
    localparam int BW = $clog2(N + 1);
    localparam int CW = $clog2(D + 1);
    localparam int WW = $clog2(SYNC_WIN + 1);

    localparam logic [W-1:0]  PM_INIT   = W'(1 << (W - 2));
    localparam logic [CW-1:0] CNT_FIRST = CW'(D - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(D);
    localparam logic [WW-1:0] WIN_LAST  = WW'(SYNC_WIN - 1);

    logic [W-1:0]  pm       [S];
    logic [D-1:0]  surv     [S];
    logic [W-1:0]  pm_new   [S];
    logic [D-1:0]  surv_new [S];
    logic [W-1:0]  m;
    logic [K-2:0]  best;
    logic [CW-1:0] cnt;
    logic [15:0]   acc;
    logic [16:0]   acc_sum;
    logic [WW-1:0] wcnt;

    // Hamming distance between Rx and the code bits of one trellis branch.
    function automatic logic [BW-1:0] branch_metric(
        input logic [N-1:0] rx,
        input logic [K-1:0] taps_in
    );
        logic [BW-1:0] sum;
        sum = '0;
        for (int j = 0; j < N; j++) begin
            sum = sum + BW'(rx[j] ^ (^(G[j*K +: K] & taps_in)));
        end
        return sum;
    endfunction

    // Metric plus branch cost, clamped at all-ones instead of wrapping.
    function automatic logic [W-1:0] sat_add(
        input logic [W-1:0]  a,
        input logic [BW-1:0] b
    );
        logic [W:0] t;
        t = {1'b0, a} + (W+1)'(b);
        return t[W] ? '1 : t[W-1:0];
    endfunction

    // One ACS unit per destination state; ties resolve to the predecessor ending in 0.
    for (genvar i = 0; i < S; i++) begin : g_acs
        localparam logic [K-2:0] NS = (K-1)'(i);
        localparam logic [K-2:0] P0 = {NS[K-3:0], 1'b0};
        localparam logic [K-2:0] P1 = {NS[K-3:0], 1'b1};
        localparam logic         U  = NS[K-2];

        logic [W-1:0] c0;
        logic [W-1:0] c1;
        logic         sel;
        logic [D-1:0] src;

        assign c0          = sat_add(pm[P0], branch_metric(Rx, {U, P0}));
        assign c1          = sat_add(pm[P1], branch_metric(Rx, {U, P1}));
        assign sel         = c1 < c0;
        assign pm_new[i]   = sel ? c1 : c0;
        assign src         = sel ? surv[P1] : surv[P0];
        assign surv_new[i] = {src[D-2:0], U};
    end

    // Smallest new metric and the lowest-index state that reaches it.
    always_comb begin
        m    = pm_new[0];
        best = '0;
        for (int i = 1; i < S; i++) begin
            if (pm_new[i] < m) begin
                m    = pm_new[i];
                best = (K-1)'(i);
            end
        end
    end

    assign acc_sum = {1'b0, acc} + 17'(m);

    // Trellis state, output strobe and sync window; all hold while seq_ready is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < S; i++) begin
                pm[i]   <= (i == 0) ? '0 : PM_INIT;
                surv[i] <= '0;
            end
            cnt        <= '0;
            acc        <= '0;
            wcnt       <= '0;
            oe         <= 1'b0;
            Dx         <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            oe <= 1'b0;
            if (seq_ready) begin
                for (int i = 0; i < S; i++) begin
                    pm[i]   <= pm_new[i] - m;
                    surv[i] <= surv_new[i];
                end
                if (cnt >= CNT_FIRST) begin
                    oe <= 1'b1;
                    Dx <= surv_new[best][D-1];
                end
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                if (wcnt == WIN_LAST) begin
                    sync_error <= acc_sum > 17'(SYNC_THR);
                    acc        <= '0;
                    wcnt       <= '0;
                end else begin
                    acc  <= acc_sum[16] ? '1 : acc_sum[15:0];
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_param_decoder.sv
// tb_viterbi_param_decoder: (7,5) K=3 decoder bench with an encoder,
// a forward-relaxation metric model and a message queue as reference.
module tb_viterbi_param_decoder;
    localparam int N = 2;
    localparam int K = 3;
    localparam int W = 8;
    localparam int D = 15;
    localparam int SYNC_WIN = 64;
    localparam int SYNC_THR = 16;
    localparam int S = 4;
    localparam int MSG_LEN = 25;
    localparam logic [5:0] G = 6'b111101;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       seq_ready = 1'b0;
    logic [1:0] rx = 2'b00;
    logic       dx;
    logic       oe;
    logic       sync_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit u;
        bit known;
    } qent_t;

    typedef struct {
        logic [1:0] rx;
        bit         u;
        bit         exp_oe;
        bit         exp_dx;
    } vec_t;

    qent_t msg_q[$];
    int    pm_m[S];
    int    m_cnt;
    int    m_acc;
    int    m_wcnt;
    bit    m_sync;
    bit    m_dx;
    bit    m_dx_known;
    bit    win_end;
    int    oe_seen;
    int    enc_st;
    bit    msg1[MSG_LEN];
    vec_t  tab[MSG_LEN];

    viterbi_param_decoder #(
        .N(N), .K(K), .G(G), .W(W), .D(D),
        .SYNC_WIN(SYNC_WIN), .SYNC_THR(SYNC_THR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .Rx(rx),
        .seq_ready(seq_ready),
        .Dx(dx),
        .oe(oe),
        .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] code_bits(input int u, input int s);
        logic [2:0] r3;
        logic [5:0] g;
        logic [1:0] c;
        g  = G;
        r3 = {u[0], s[1], s[0]};
        for (int j = 0; j < N; j++) c[j] = ^(g[j*K +: K] & r3);
        return c;
    endfunction

    function automatic int hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return int'(x[0]) + int'(x[1]);
    endfunction

    function automatic logic [1:0] encode(input bit u);
        logic [1:0] c;
        c      = code_bits(int'(u), enc_st);
        enc_st = (int'(u) << 1) | (enc_st >> 1);
        return c;
    endfunction

    task automatic model_reset();
        pm_m[0] = 0;
        for (int s = 1; s < S; s++) pm_m[s] = 1 << (W - 2);
        m_cnt = 0;
        m_acc = 0;
        m_wcnt = 0;
        m_sync = 0;
        m_dx = 0;
        m_dx_known = 1;
        win_end = 0;
        oe_seen = 0;
        enc_st = 0;
        msg_q.delete();
    endtask

    task automatic model_accept(input logic [1:0] r, output bit exp_oe);
        int    nw[S];
        int    mn;
        int    ns;
        int    c;
        qent_t e;
        for (int s = 0; s < S; s++) nw[s] = 1 << 30;
        for (int s = 0; s < S; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns = (u << 1) | (s >> 1);
                c  = pm_m[s] + hamming(r, code_bits(u, s));
                if (c > (1 << W) - 1) c = (1 << W) - 1;
                if (c < nw[ns]) nw[ns] = c;
            end
        end
        mn = nw[0];
        for (int s = 1; s < S; s++) if (nw[s] < mn) mn = nw[s];
        for (int s = 0; s < S; s++) pm_m[s] = nw[s] - mn;
        m_acc += mn;
        m_wcnt++;
        win_end = 0;
        if (m_wcnt == SYNC_WIN) begin
            m_sync  = m_acc > SYNC_THR;
            m_acc   = 0;
            m_wcnt  = 0;
            win_end = 1;
        end
        exp_oe = m_cnt >= D - 1;
        if (m_cnt < D) m_cnt++;
        if (exp_oe) begin
            e = msg_q.pop_front();
            m_dx = e.u;
            m_dx_known = e.known;
        end
    endtask

    task automatic apply(input logic [1:0] r, input bit rdy, input bit u, input bit known);
        bit exp_oe;
        rx = r;
        seq_ready = rdy;
        exp_oe = 0;
        win_end = 0;
        if (rdy) begin
            msg_q.push_back('{u: u, known: known});
            model_accept(r, exp_oe);
        end
        @(posedge clock);
        #1;
        chk("oe", oe, exp_oe);
        if (m_dx_known) chk("dx", dx, m_dx);
        chk("sync_error", sync_error, m_sync);
        if (oe) oe_seen++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        seq_ready = 1'($urandom_range(0, 1));
        rx = 2'($urandom);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_oe", oe, 1'b0);
        chk("rst_dx", dx, 1'b0);
        chk("rst_sync", sync_error, 1'b0);
    endtask

    task automatic send_msg1(input int count, input bit gaps);
        int ng;
        for (int k = 0; k < count; k++) begin
            apply(encode(msg1[k]), 1'b1, msg1[k], 1'b1);
            if (gaps) begin
                ng = 2 + $urandom_range(0, 2);
                for (int g = 0; g < ng; g++) apply(2'($urandom), 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        logic [9:0] u1;
        logic [1:0] r;
        bit         prbs_flag;
        bit         b;
        int         wins;

        u1 = 10'b1011001110;
        for (int k = 0; k < MSG_LEN; k++) msg1[k] = (k < 10) ? u1[9-k] : 1'b0;

        enc_st = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            tab[k].rx = encode(msg1[k]);
            tab[k].u = msg1[k];
            tab[k].exp_oe = (k + 1) >= D;
            if ((k + 1) >= D) tab[k].exp_dx = msg1[k + 1 - D];
            else tab[k].exp_dx = 1'b0;
        end

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Test 1: table of clean (7,5) symbols, continuous accept.
        for (int k = 0; k < MSG_LEN; k++) begin
            apply(tab[k].rx, 1'b1, tab[k].u, 1'b1);
            chk("t1_oe", oe, tab[k].exp_oe);
            chk("t1_dx", dx, tab[k].exp_dx);
        end
        chk_int("t1_oe_count", oe_seen, MSG_LEN - D + 1);

        // Test 2: two single-bit channel errors.
        do_reset();
        for (int k = 0; k < MSG_LEN; k++) begin
            r = encode(msg1[k]);
            if (k == 2) r[0] = ~r[0];
            if (k == 8) r[1] = ~r[1];
            apply(r, 1'b1, msg1[k], 1'b1);
        end
        chk_int("t2_oe_count", oe_seen, MSG_LEN - D + 1);
        chk("t2_sync", sync_error, 1'b0);

        // Test 3: 1-on/2-off pattern with extra random gaps.
        do_reset();
        send_msg1(MSG_LEN, 1'b1);
        chk_int("t3_oe_count", oe_seen, MSG_LEN - D + 1);

        // Test 4: reset after the 20th accept, then a clean replay.
        do_reset();
        send_msg1(20, 1'b0);
        do_reset();
        send_msg1(MSG_LEN, 1'b0);
        chk_int("t4_oe_count", oe_seen, MSG_LEN - D + 1);

        // Test 5: long random error-free message.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            b = 1'($urandom_range(0, 1));
            apply(encode(b), 1'b1, b, 1'b1);
        end
        chk_int("t5_oe_count", oe_seen, 4000 - D + 1);
        chk("t5_sync", sync_error, 1'b0);

        // Test 6: PRBS Rx for 256 symbols, then valid code again.
        do_reset();
        prbs_flag = 0;
        for (int k = 0; k < 256; k++) begin
            apply(2'($urandom), 1'b1, 1'b0, 1'b0);
            if (win_end && sync_error) prbs_flag = 1;
        end
        chk("t6_sync_in_prbs", prbs_flag, 1'b1);
        wins = 0;
        for (int k = 0; k < 256; k++) begin
            b = 1'($urandom_range(0, 1));
            apply(encode(b), 1'b1, b, 1'b0);
            if (win_end) begin
                wins++;
                if (wins == 2) chk("t6_sync_recover", sync_error, 1'b0);
            end
        end
        chk_int("t6_windows", wins, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
